// File: rtl/between_to_in.sv
// between_to_in: receive stage of the 8-bit parallel link. It captures a byte on tsent, acknowledges it with trecieve, and buffers it in an FWFT FIFO.
// Optional macro BETWEEN_SYNC_EN places a 2-flop synchronizer on tsent.
module between_to_in #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              t0,
  input  logic              t1,
  input  logic              t2,
  input  logic              t3,
  input  logic              t4,
  input  logic              t5,
  input  logic              t6,
  input  logic              t7,
  input  logic              tsent,
  output logic              trecieve,
  output logic [7:0]        dout,
  output logic              dvalid,
  input  logic              dready,
  output logic [ADDR_W:0]   level,
  output logic [CNT_W-1:0]  rx_count
);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  localparam logic [ADDR_W:0] L_FULL = (ADDR_W + 1)'(DEPTH);

  state_t             r_state;
  state_t             w_state_next;
  logic               r_trecieve;
  logic [7:0]         r_mem [DEPTH];
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [ADDR_W:0]    r_level;
  logic [CNT_W-1:0]   r_rx_count;
  logic               w_tsent_s;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic [7:0]         w_byte;

  // t0 is the MSB of the link byte.
  assign w_byte = {t0, t1, t2, t3, t4, t5, t6, t7};

`ifdef BETWEEN_SYNC_EN
  logic [1:0] r_sync;
  always_ff @(posedge clk) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[0], tsent};
  end
  assign w_tsent_s = r_sync[1];
`else
  assign w_tsent_s = tsent;
`endif

  // Full is judged on the pre-pop level, so a same-cycle pop never unblocks a capture.
  assign w_full = (r_level == L_FULL);
  assign dvalid = (r_level != '0);
  assign w_pop  = dvalid && dready;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_state_next = r_state;
    w_push       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tsent_s && !w_full) begin
          w_push       = 1'b1;
          w_state_next = S_ACK;
        end
      end
      S_ACK: begin
        if (!w_tsent_s) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_trecieve <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_rx_count <= '0;
    end else begin
      r_state    <= w_state_next;
      r_trecieve <= (w_state_next == S_ACK);
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_rx_count <= r_rx_count + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // NOTE: the storage array has no reset; dout is masked while empty, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_byte;
  end

  assign dout     = dvalid ? r_mem[r_rd_ptr] : 8'h00;
  assign trecieve = r_trecieve;
  assign level    = r_level;
  assign rx_count = r_rx_count;

endmodule

// File: tb/tb_between_to_in.sv
// Self-checking bench for between_to_in (default build, no tsent synchronizer).
// It runs a directed vector table, hand-written sender sequences, and a randomized run checked against a queue-based model.
module tb_between_to_in;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        t0, t1, t2, t3, t4, t5, t6, t7;
  logic        tsent;
  logic        trecieve;
  logic [7:0]  dout;
  logic        dvalid;
  logic        dready;
  logic [2:0]  level;
  logic [15:0] rx_count;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] got[$];

  between_to_in #(.DEPTH(DEPTH), .ADDR_W(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .t0(t0), .t1(t1), .t2(t2), .t3(t3), .t4(t4), .t5(t5), .t6(t6), .t7(t7),
    .tsent(tsent), .trecieve(trecieve),
    .dout(dout), .dvalid(dvalid), .dready(dready),
    .level(level), .rx_count(rx_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ts;
    logic        dr;
    logic [7:0]  b;
    logic        tr;
    logic        dv;
    logic [7:0]  dout;
    logic [2:0]  lvl;
    logic [15:0] rx;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic ts, logic dr, logic [7:0] b, logic tr, logic dv,
                              logic [7:0] d, logic [2:0] lvl, logic [15:0] rx);
    vec_t v;
    v.ts = ts; v.dr = dr; v.b = b; v.tr = tr; v.dv = dv; v.dout = d; v.lvl = lvl; v.rx = rx;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_byte(input logic [7:0] b);
    {t0, t1, t2, t3, t4, t5, t6, t7} = b;
  endtask

  // Record the byte the consumer takes at the coming edge, then advance one cycle.
  task automatic cycle();
    if (dvalid && dready) got.push_back(dout);
    tick();
  endtask

  task automatic reset_dut();
    reset = 1'b1; tsent = 1'b0; dready = 1'b0; set_byte(8'h00);
    tick(); tick();
    reset = 1'b0;
  endtask

  // Sender behaviour: hold the byte with tsent until trecieve, then drop tsent and wait for trecieve to clear.
  task automatic send_byte(input logic [7:0] b, input bit release_strobe);
    int k;
    set_byte(b);
    tsent = 1'b1;
    k = 0;
    while (!trecieve && k < 50) begin cycle(); k++; end
    if (!trecieve) check("ack_timeout", 32'(trecieve), 32'd1);
    if (release_strobe) begin
      tsent = 1'b0;
      k = 0;
      while (trecieve && k < 50) begin cycle(); k++; end
      if (trecieve) check("ack_release_timeout", 32'(trecieve), 32'd0);
    end
  endtask

  // Behavioural model state: buffered bytes, acknowledge flag, received count.
  logic [7:0] m_q[$];
  bit         m_ack;
  int         m_rx;

  task automatic model_step(input logic ts, input logic dr, input logic [7:0] b);
    int  pre;
    bit  do_push, do_pop;
    pre     = m_q.size();
    do_pop  = (pre > 0) && dr;
    do_push = !m_ack && ts && (pre < DEPTH);
    if (do_pop) void'(m_q.pop_front());
    if (do_push) begin
      m_q.push_back(b);
      m_rx++;
      m_ack = 1'b1;
    end else if (m_ack && !ts) begin
      m_ack = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; tsent = 1'b0; dready = 1'b0; set_byte(8'h00);

    // Reset, then idle for 10 cycles.
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_trecieve", 32'(trecieve), 32'd0);
      check("idle_dvalid",   32'(dvalid),   32'd0);
      check("idle_level",    32'(level),    32'd0);
      check("idle_rx_count", 32'(rx_count), 32'd0);
      check("idle_dout",     32'(dout),     32'd0);
    end

    // Directed table: single byte, back-pressure, push/pop at level 2, re-raise held in ACK.
    tbl.push_back(mk(1, 0, 8'hA5, 1, 1, 8'hA5, 1, 1));
    tbl.push_back(mk(0, 0, 8'hA5, 0, 1, 8'hA5, 1, 1));
    tbl.push_back(mk(0, 1, 8'h00, 0, 0, 8'h00, 0, 1));
    tbl.push_back(mk(1, 0, 8'h01, 1, 1, 8'h01, 1, 2));
    tbl.push_back(mk(0, 0, 8'h01, 0, 1, 8'h01, 1, 2));
    tbl.push_back(mk(1, 0, 8'h02, 1, 1, 8'h01, 2, 3));
    tbl.push_back(mk(0, 0, 8'h02, 0, 1, 8'h01, 2, 3));
    tbl.push_back(mk(1, 0, 8'h03, 1, 1, 8'h01, 3, 4));
    tbl.push_back(mk(0, 0, 8'h03, 0, 1, 8'h01, 3, 4));
    tbl.push_back(mk(1, 0, 8'h04, 1, 1, 8'h01, 4, 5));
    tbl.push_back(mk(0, 0, 8'h04, 0, 1, 8'h01, 4, 5));
    tbl.push_back(mk(1, 0, 8'h05, 0, 1, 8'h01, 4, 5));
    tbl.push_back(mk(1, 0, 8'h05, 0, 1, 8'h01, 4, 5));
    tbl.push_back(mk(1, 1, 8'h05, 0, 1, 8'h02, 3, 5));
    tbl.push_back(mk(1, 0, 8'h05, 1, 1, 8'h02, 4, 6));
    tbl.push_back(mk(0, 0, 8'h05, 0, 1, 8'h02, 4, 6));
    tbl.push_back(mk(0, 1, 8'h00, 0, 1, 8'h03, 3, 6));
    tbl.push_back(mk(0, 1, 8'h00, 0, 1, 8'h04, 2, 6));
    tbl.push_back(mk(1, 1, 8'h06, 1, 1, 8'h05, 2, 7));
    tbl.push_back(mk(0, 0, 8'h06, 0, 1, 8'h05, 2, 7));
    tbl.push_back(mk(1, 0, 8'h07, 1, 1, 8'h05, 3, 8));
    tbl.push_back(mk(1, 0, 8'h08, 1, 1, 8'h05, 3, 8));
    tbl.push_back(mk(0, 0, 8'h08, 0, 1, 8'h05, 3, 8));
    foreach (tbl[i]) begin
      tsent = tbl[i].ts; dready = tbl[i].dr; set_byte(tbl[i].b);
      tick();
      check($sformatf("tbl%0d_trecieve", i), 32'(trecieve), 32'(tbl[i].tr));
      check($sformatf("tbl%0d_dvalid", i),   32'(dvalid),   32'(tbl[i].dv));
      check($sformatf("tbl%0d_level", i),    32'(level),    32'(tbl[i].lvl));
      check($sformatf("tbl%0d_rx_count", i), 32'(rx_count), 32'(tbl[i].rx));
      if (tbl[i].dv) check($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].dout));
    end

    // Ordering and pointer wrap with a free-running consumer.
    reset_dut();
    dready = 1'b1;
    got.delete();
    for (int i = 0; i < 10; i++) send_byte(8'h10 + 8'(i), 1'b1);
    for (int i = 0; i < 6; i++) cycle();
    check("wrap_count", 32'(got.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < got.size()) check($sformatf("wrap_byte%0d", i), 32'(got[i]), 32'(8'h10 + 8'(i)));
    end
    check("wrap_rx_count", 32'(rx_count), 32'd10);
    check("wrap_level",    32'(level),    32'd0);

    // Reset asserted while in ACK with three bytes buffered.
    reset_dut();
    send_byte(8'h31, 1'b1);
    send_byte(8'h32, 1'b1);
    send_byte(8'h33, 1'b0);
    check("pre_reset_level", 32'(level), 32'd3);
    reset = 1'b1; tsent = 1'b0;
    tick();
    check("midreset_trecieve", 32'(trecieve), 32'd0);
    check("midreset_level",    32'(level),    32'd0);
    check("midreset_dvalid",   32'(dvalid),   32'd0);
    check("midreset_dout",     32'(dout),     32'd0);
    reset = 1'b0;
    tick();
    send_byte(8'h3C, 1'b1);
    check("post_reset_dout",     32'(dout),     32'h3C);
    check("post_reset_dvalid",   32'(dvalid),   32'd1);
    check("post_reset_level",    32'(level),    32'd1);
    check("post_reset_rx_count", 32'(rx_count), 32'd1);

    // Randomized stimulus against the queue model.
    reset_dut();
    m_q.delete(); m_ack = 1'b0; m_rx = 0;
    for (int i = 0; i < 400; i++) begin
      logic       ts, dr;
      logic [7:0] b;
      ts = ($urandom_range(0, 9) < 6);
      dr = ($urandom_range(0, 9) < 4);
      b  = 8'($urandom);
      tsent = ts; dready = dr; set_byte(b);
      model_step(ts, dr, b);
      tick();
      check("rnd_trecieve", 32'(trecieve), 32'(m_ack));
      check("rnd_dvalid",   32'(dvalid),   32'(m_q.size() > 0));
      check("rnd_level",    32'(level),    32'(m_q.size()));
      check("rnd_rx_count", 32'(rx_count), 32'(m_rx[15:0]));
      if (m_q.size() > 0) check("rnd_dout", 32'(dout), 32'(m_q[0]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
